// File: rtl/tlc_pkg.sv
// tlc_pkg: phase encoding, lamp codes and lamp decode
// shared by the traffic phase controller files
package tlc_pkg;

  typedef enum logic [2:0] {
    PH_NS_GRN = 3'd0,
    PH_NS_YEL = 3'd1,
    PH_AR1    = 3'd2,
    PH_EW_GRN = 3'd3,
    PH_EW_YEL = 3'd4,
    PH_AR2    = 3'd5,
    PH_WALK   = 3'd6
  } phase_t;

  localparam logic [2:0] LAMP_RED = 3'b100;
  localparam logic [2:0] LAMP_YEL = 3'b010;
  localparam logic [2:0] LAMP_GRN = 3'b001;

  function automatic logic [2:0] ns_lamp(input phase_t p);
    logic [2:0] l;
    l = LAMP_RED;
    case (p)
      PH_NS_GRN: l = LAMP_GRN;
      PH_NS_YEL: l = LAMP_YEL;
      default:   l = LAMP_RED;
    endcase
    return l;
  endfunction

  function automatic logic [2:0] ew_lamp(input phase_t p);
    logic [2:0] l;
    l = LAMP_RED;
    case (p)
      PH_EW_GRN: l = LAMP_GRN;
      PH_EW_YEL: l = LAMP_YEL;
      default:   l = LAMP_RED;
    endcase
    return l;
  endfunction

endpackage

// File: rtl/tlc_ped_latch.sv
// tlc_ped_latch: pending pedestrian request and one-cycle
// acknowledge marking the walk entry cycle
module tlc_ped_latch (
  input  logic clk,
  input  logic rst_n,
  input  logic i_req,
  input  logic i_enter,
  output logic o_pend,
  output logic o_ack
);

  logic r_pend;
  logic r_ack;

  // set outside the walk entry cycle, cleared when walk is entered
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pend <= 1'b0;
      r_ack  <= 1'b0;
    end else begin
      r_ack <= i_enter;
      if (i_enter)
        r_pend <= 1'b0;
      else if (i_req && !r_ack)
        r_pend <= 1'b1;
    end
  end

  // a request raised in the deciding cycle counts immediately
  assign o_pend = r_pend | i_req;
  assign o_ack  = r_ack;

endmodule

// File: rtl/traffic_phase_ctrl.sv
// traffic_phase_ctrl: phase sequencer driving an external interval timer.
// Define TLC_PED_EN to build in the pedestrian walk phase.
module traffic_phase_ctrl
  import tlc_pkg::*;
#(
  parameter int N        = 4,
  parameter int T_GREEN  = 10,
  parameter int T_YELLOW = 3,
  parameter int T_ALLRED = 1,
  parameter int T_WALK   = 6
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         tmr_done,
  output logic [N-1:0] tmr_final_value,
  output logic         tmr_restart,
  output logic [2:0]   ns_light,
  output logic [2:0]   ew_light,
  input  logic         ped_req,
  output logic         ped_ack,
  output logic         walk
);

  localparam int TMAX = (1 << N) - 1;

  if (T_GREEN > TMAX || T_YELLOW > TMAX ||
      T_ALLRED > TMAX || T_WALK > TMAX) begin : g_range_err
    $error("traffic_phase_ctrl: duration exceeds timer range");
  end

  phase_t       r_phase;
  phase_t       w_nxt;
  logic         r_restart;
  logic [N-1:0] r_fv;
  logic [2:0]   r_ns;
  logic [2:0]   r_ew;
  logic [N-1:0] w_fv;
  logic         w_adv;
  logic         w_bad;
  logic         w_pend;

  // a match seen in a restart cycle is stale and never advances
  assign w_adv = tmr_done & ~r_restart;

  // next phase from the fixed ring, walk inserted after all-red 2
  always_comb begin
    w_nxt = r_phase;
    w_bad = 1'b0;
    case (r_phase)
      PH_NS_GRN: if (w_adv) w_nxt = PH_NS_YEL;
      PH_NS_YEL: if (w_adv) w_nxt = PH_AR1;
      PH_AR1:    if (w_adv) w_nxt = PH_EW_GRN;
      PH_EW_GRN: if (w_adv) w_nxt = PH_EW_YEL;
      PH_EW_YEL: if (w_adv) w_nxt = PH_AR2;
      PH_AR2:    if (w_adv) w_nxt = w_pend ? PH_WALK : PH_NS_GRN;
`ifdef TLC_PED_EN
      PH_WALK:   if (w_adv) w_nxt = PH_NS_GRN;
`endif
      default: begin
        w_nxt = PH_AR2;
        w_bad = 1'b1;
      end
    endcase
  end

  // duration of the phase being entered
  always_comb begin
    w_fv = N'(T_ALLRED);
    case (w_nxt)
      PH_NS_GRN, PH_EW_GRN: w_fv = N'(T_GREEN);
      PH_NS_YEL, PH_EW_YEL: w_fv = N'(T_YELLOW);
`ifdef TLC_PED_EN
      PH_WALK:              w_fv = N'(T_WALK);
`endif
      default:              w_fv = N'(T_ALLRED);
    endcase
  end

  // phase and its registered outputs change on the same edge
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_phase   <= PH_AR2;
      r_restart <= 1'b1;
      r_fv      <= N'(T_ALLRED);
      r_ns      <= LAMP_RED;
      r_ew      <= LAMP_RED;
    end else begin
      r_phase   <= w_nxt;
      r_restart <= w_adv | w_bad;
      r_fv      <= w_fv;
      r_ns      <= ns_lamp(w_nxt);
      r_ew      <= ew_lamp(w_nxt);
    end
  end

  assign tmr_restart     = r_restart;
  assign tmr_final_value = r_fv;
  assign ns_light        = r_ns;
  assign ew_light        = r_ew;

`ifdef TLC_PED_EN
  logic r_walk;
  logic w_enter;

  assign w_enter = (r_phase == PH_AR2) && (w_nxt == PH_WALK);

  // walk lamp lit for the whole walk phase
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      r_walk <= 1'b0;
    else
      r_walk <= (w_nxt == PH_WALK);
  end

  tlc_ped_latch u_ped (
    .clk     (clk),
    .rst_n   (reset_n),
    .i_req   (ped_req),
    .i_enter (w_enter),
    .o_pend  (w_pend),
    .o_ack   (ped_ack)
  );

  assign walk = r_walk;
`else
  logic w_unused;

  assign w_unused = ped_req;
  assign w_pend   = 1'b0;
  assign ped_ack  = 1'b0;
  assign walk     = 1'b0;
`endif

endmodule

// File: tb/tb_traffic_phase_ctrl.sv
// tb_traffic_phase_ctrl: phase-table model with a behavioural
// interval timer, plus directed literal checks
`timescale 1ns/1ps
module tb_traffic_phase_ctrl;

  localparam int N = 4;
  localparam logic [2:0] RED = 3'b100;
  localparam logic [2:0] YEL = 3'b010;
  localparam logic [2:0] GRN = 3'b001;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         tmr_done;
  logic [N-1:0] tmr_final_value;
  logic         tmr_restart;
  logic [2:0]   ns_light;
  logic [2:0]   ew_light;
  logic         ped_req = 1'b0;
  logic         ped_ack;
  logic         walk;
  logic         force_done = 1'b0;

  int n_chk = 0;
  int n_err = 0;
  int cyc = 0;
  int cnt = 0;

  always #5 clk = ~clk;

  traffic_phase_ctrl #(
    .N(4), .T_GREEN(10), .T_YELLOW(3), .T_ALLRED(1), .T_WALK(6)
  ) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .tmr_done        (tmr_done),
    .tmr_final_value (tmr_final_value),
    .tmr_restart     (tmr_restart),
    .ns_light        (ns_light),
    .ew_light        (ew_light),
    .ped_req         (ped_req),
    .ped_ack         (ped_ack),
    .walk            (walk)
  );

  // interval timer: clears on restart, counts up and holds at match
  always @(posedge clk) begin
    if (tmr_restart)
      cnt <= 0;
    else if (cnt != int'(tmr_final_value))
      cnt <= cnt + 1;
  end
  assign tmr_done = (cnt == int'(tmr_final_value)) |
                    (force_done & tmr_restart);

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)",
               nm, act, exp, $time);
    end
  endtask

  // phase table: 0 NSG 1 NSY 2 AR1 3 EWG 4 EWY 5 AR2 6 WALK
  int         dur [7]  = '{10, 3, 1, 10, 3, 1, 6};
  logic [2:0] ns_t [7] = '{GRN, YEL, RED, RED, RED, RED, RED};
  logic [2:0] ew_t [7] = '{RED, RED, RED, GRN, YEL, RED, RED};
  int         succ [7] = '{1, 2, 3, 4, 5, 0, 0};
  int m_ph = 5;
  int m_k = 0;
  bit m_pend = 1'b0;
  int ng_q[$];

  // every cycle: compare against the phase table, then step the model
  always @(negedge clk) begin : cmp
    int  nx;
    bit  clr;
    bit  in_entry;
    cyc++;
    if (!reset_n) begin
      m_ph = 5; m_k = 0; m_pend = 1'b0;
    end
    chk("ns", ns_light, ns_t[m_ph]);
    chk("ew", ew_light, ew_t[m_ph]);
    chk("fv", tmr_final_value, dur[m_ph]);
    chk("restart", tmr_restart, m_k == 0);
    chk("walk", walk, m_ph == 6);
    chk("ack", ped_ack, m_ph == 6 && m_k == 0);
    chk("excl", ns_light != RED && ew_light != RED, 0);
    if (tmr_restart && ns_light == GRN)
      ng_q.push_back(cyc);
    if (reset_n) begin
      clr = 1'b0;
      in_entry = (m_ph == 6 && m_k == 0);
      if (m_k == dur[m_ph] + 1) begin
        nx = succ[m_ph];
`ifdef TLC_PED_EN
        if (m_ph == 5 && (m_pend || ped_req)) begin
          nx = 6; clr = 1'b1;
        end
`endif
        m_ph = nx;
        m_k = 0;
      end else begin
        m_k++;
      end
      if (clr)
        m_pend = 1'b0;
      else if (ped_req && !in_entry)
        m_pend = 1'b1;
    end
  end

  task automatic run_len(input logic [2:0] a, input logic [2:0] b,
                         output int n);
    n = 0;
    while (ns_light == a && ew_light == b && n < 200) begin
      n++;
      @(negedge clk);
    end
  endtask

  // reset release to the start of east-west green
  task automatic startup();
    int n;
    @(negedge clk);
    n = 0;
    while (ns_light != GRN && n < 200) begin
      n++;
      @(negedge clk);
    end
    chk("ar2_len", n, 3);
    chk("ng_fv", tmr_final_value, 10);
    run_len(GRN, RED, n);
    chk("ng_len", n, 12);
    chk("ny_fv", tmr_final_value, 3);
    run_len(YEL, RED, n);
    chk("ny_len", n, 5);
    chk("ar1_fv", tmr_final_value, 1);
    run_len(RED, RED, n);
    chk("ar1_len", n, 3);
    chk("eg_ew", ew_light, GRN);
  endtask

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin : main
    int n;
    int acks;
    int walks;
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_fv", tmr_final_value, 1);
    chk("rst_restart", tmr_restart, 1);
    chk("rst_ns", ns_light, RED);
    chk("rst_ew", ew_light, RED);
    chk("rst_walk", walk, 0);
    chk("rst_ack", ped_ack, 0);
    @(posedge clk); #1 reset_n = 1'b1;
    startup();

    n = 0;
    while (ng_q.size() < 2 && n < 200) begin
      n++;
      @(negedge clk);
    end
    chk("period", ng_q.size() >= 2 ? ng_q[1] - ng_q[0] : -1, 40);

    @(posedge clk); #1 force_done = 1'b1;
    n = 0;
    while (ns_light != YEL && n < 200) begin
      n++;
      @(negedge clk);
    end
    run_len(YEL, RED, n);
    chk("ny_len_forced", n, 5);
    run_len(RED, RED, n);
    chk("ar1_len_forced", n, 3);
    repeat (40) @(negedge clk);
    @(posedge clk); #1 force_done = 1'b0;

`ifdef TLC_PED_EN
    n = 0;
    while (ns_light != GRN && n < 200) begin
      n++;
      @(negedge clk);
    end
    repeat (3) @(posedge clk);
    #1 ped_req = 1'b1;
    n = 0;
    while (!ped_ack && n < 200) begin
      n++;
      @(posedge clk); #1;
    end
    chk("ack_seen", ped_ack, 1);
    chk("walk_on", walk, 1);
    chk("walk_ns", ns_light, RED);
    chk("walk_fv", tmr_final_value, 6);
    n = 0;
    while (walk && n < 200) begin
      n++;
      @(posedge clk); #1 ped_req = 1'b0;
      if (n == 1) chk("ack_pulse", ped_ack, 0);
    end
    chk("walk_len", n, 8);
    chk("after_walk_ns", ns_light, GRN);

    ped_req = 1'b1;
    n = 0;
    while (!ped_ack && n < 200) begin
      n++;
      @(posedge clk); #1;
    end
    @(posedge clk); #1 ped_req = 1'b0;
    repeat (2) @(posedge clk);
    #1 ped_req = 1'b1;
    @(posedge clk); #1 ped_req = 1'b0;
    acks = 0;
    n = 0;
    while (n < 60 && acks == 0) begin
      @(posedge clk); #1;
      n++;
      if (ped_ack) acks++;
    end
    chk("walk_req_served", acks, 1);
    ped_req = 1'b1;
    @(posedge clk); #1 ped_req = 1'b0;
    acks = 0;
    repeat (60) begin
      @(posedge clk); #1;
      if (ped_ack) acks++;
    end
    chk("entry_pulse_ignored", acks, 0);
`else
    @(posedge clk); #1 ped_req = 1'b1;
    acks = 0;
    walks = 0;
    repeat (60) begin
      @(posedge clk); #1;
      if (ped_ack) acks++;
      if (walk) walks++;
    end
    ped_req = 1'b0;
    chk("noped_acks", acks, 0);
    chk("noped_walks", walks, 0);
`endif

    n = 0;
    while (ew_light != GRN && n < 200) begin
      n++;
      @(negedge clk);
    end
    @(posedge clk); #1;
    @(posedge clk); #3 reset_n = 1'b0;
    #1;
    chk("mid_rst_ns", ns_light, RED);
    chk("mid_rst_ew", ew_light, RED);
    chk("mid_rst_restart", tmr_restart, 1);
    chk("mid_rst_fv", tmr_final_value, 1);
    @(posedge clk); #1 reset_n = 1'b1;
    startup();

    repeat (5) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/traffic_phase_ctrl.md
# traffic_phase_ctrl

Traffic-light phase sequencer that consumes the intersection interval timer. It drives the timer's `final_value`, restarts it on every phase entry, and consumes `done` to advance through the north-south and east-west green, yellow and all-red phases. It also has an optional pedestrian walk phase. It sits between the timer instance and the lamp drivers at the top level.

## Interface
- `N`, 4: timer width; every duration parameter must be ≤ 2^N−1 (elaboration error otherwise).
- `T_GREEN`, 10: green phase parameter.
- `T_YELLOW`, 3: yellow phase parameter.
- `T_ALLRED`, 1: all-red phase parameter.
- `T_WALK`, 6: walk phase parameter.
- `clk` in 1: single clock, rising edge.
- `reset_n` in 1: one clock; reset is asynchronous and active-low.
- `tmr_done` in 1: timer match flag (count == final_value), combinational from the timer.
- `tmr_final_value` out N: duration of the current phase, held constant for the whole phase.
- `tmr_restart` out 1: one-cycle pulse in the first cycle of every phase; the timer clears its count to 0 on that edge.
- `ns_light` out 3: {red, yellow, green}, one-hot.
- `ew_light` out 3: {red, yellow, green}, one-hot.
- `ped_req` in 1: pedestrian request, synchronous to `clk`; the requester holds it high until it sees `ped_ack`.
- `ped_ack` out 1: one-cycle acknowledge.
- `walk` out 1: walk lamp.

## Operation
- Phase order: NS_GREEN → NS_YELLOW → ALL_RED_1 → EW_GREEN → EW_YELLOW → ALL_RED_2 → (WALK if a request is pending) → NS_GREEN.
- Lamps per phase:
  - NS_GREEN: ns = green, ew = red.
  - NS_YELLOW: ns = yellow, ew = red.
  - EW_GREEN: ew = green, ns = red.
  - EW_YELLOW: ew = yellow, ns = red.
  - ALL_RED_x and WALK: both red.
  - `walk` = 1 only in WALK.
- Phase exit: taken on the edge ending any cycle where `tmr_done` = 1 and `tmr_restart` = 0. `tmr_done` is ignored in restart cycles, so a stale match from the previous phase never advances.
- Phase length: exactly T+2 cycles (entry cycle, then count 0..T).
- `tmr_final_value` per phase: T_GREEN, T_YELLOW, T_ALLRED or T_WALK. It is registered and updates on the same edge as the phase.
- Pending-request flag:
  - Set by `ped_req` = 1 in any cycle except the WALK entry cycle.
  - Cleared on the WALK entry edge; clear has priority there.
  - `ped_ack` = 1 exactly in the WALK entry cycle.
  - A request that arrives during WALK is kept pending and served after the next ALL_RED_2.
- Reset (asynchronous, any time, including mid-phase):
  - Phase goes to ALL_RED_2; pending is cleared.
  - Outputs during reset: `ns_light` = `ew_light` = 3'b100, `walk` = 0, `ped_ack` = 0, `tmr_final_value` = T_ALLRED, `tmr_restart` = 1.
  - The first cycle after release is therefore the ALL_RED_2 entry cycle.
- Illegal state encodings recover to ALL_RED_2 with `tmr_restart` = 1.

## Timing
- All outputs are registered; there is no combinational path from input to output.
- `tmr_done` → new phase, lamps and `tmr_restart`: 1 cycle.
- `ped_req` high at the end of ALL_RED_2 → WALK taken at that phase exit (same edge).

## Configuration
- `TLC_PED_EN`:
  - Defined: pending flag, WALK state and the `ped_ack`/`walk` logic are compiled in.
  - Undefined: `ped_req` is ignored; `ped_ack` and `walk` are tied to 0; ALL_RED_2 → NS_GREEN unconditionally; T_WALK is unused.
- Ports are identical in both builds.

## Structure
- Package `tlc_pkg`:
  - Phase enum (3 bits).
  - Lamp constants LAMP_RED = 3'b100, LAMP_YEL = 3'b010, LAMP_GRN = 3'b001.
- One sub-module, `tlc_ped_latch`: pending-flag set/clear and `ped_ack` generation, instantiated only under `TLC_PED_EN`.
- The timer stays external; this block only drives and consumes its interface.

## Test plan
- Reset release with a behavioural timer model, defaults: `tmr_restart` = 1 in the first cycle; ALL_RED_2 lasts 3 cycles; then NS_GREEN lasts 12 cycles, NS_YELLOW 5 and ALL_RED_1 3, with matching `tmr_final_value` values 10, 3, 1.
- Full cycle with no requests: sequence repeats with period 2·(12+5+3) = 40 cycles; ns/ew never both non-red.
- `ped_req` raised mid NS_GREEN and held until ack: after ALL_RED_2, WALK is entered with `ped_ack` = 1 for 1 cycle; `walk` = 1 for 8 cycles with both lamps red; then NS_GREEN.
- `ped_req` pulsed in the WALK entry cycle only: not re-latched; no second WALK.
- `tmr_done` forced high in a restart cycle: phase does not advance.
- `reset_n` low mid EW_GREEN: lamps are both red immediately; sequence restarts per the first scenario.
- `TLC_PED_EN` undefined, `ped_req` held at 1: no WALK; `ped_ack` = `walk` = 0 throughout.
